// File: rtl/rv_enc_pkg.sv
// Shared RV32IF encoding definitions: instruction formats, major opcodes and the
// legal format/opcode table used by both the encoder and the PE decoder.
package rv_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_R4  = 3'd6,
        FMT_RSV = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FP     = 7'b1010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FLW    = 7'b0000111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_FSW    = 7'b0100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_FMADD  = 7'b1000011;
    localparam logic [6:0] OP_FMSUB  = 7'b1000111;
    localparam logic [6:0] OP_FNMSUB = 7'b1001011;
    localparam logic [6:0] OP_FNMADD = 7'b1001111;

    function automatic logic is_legal_op(input fmt_e fmt, input logic [6:0] op);
        logic ok;
        ok = 1'b0;
        case (fmt)
            FMT_R:   ok = (op == OP_REG) || (op == OP_FP);
            FMT_I:   ok = (op == OP_LOAD) || (op == OP_IMM) || (op == OP_JALR) || (op == OP_FLW);
            FMT_S:   ok = (op == OP_STORE) || (op == OP_FSW);
            FMT_B:   ok = (op == OP_BRANCH);
            FMT_U:   ok = (op == OP_LUI) || (op == OP_AUIPC);
            FMT_J:   ok = (op == OP_JAL);
            FMT_R4:  ok = (op == OP_FMADD) || (op == OP_FMSUB) || (op == OP_FNMSUB) || (op == OP_FNMADD);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rv_instr_encoder_if.sv
// Field-bundle input handshake and encoded-word output handshake of the encoder.
interface rv_instr_encoder_if #(parameter int ADDR_W = 8);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_op;
    logic [1:0]        in_funct2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [4:0]        in_rs3;
    logic [4:0]        in_rd;
    logic [11:0]       in_imm12;
    logic [19:0]       in_immhi;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_fmt, in_op, in_funct2, in_funct3, in_funct7,
               in_rs1, in_rs2, in_rs3, in_rd, in_imm12, in_immhi, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, in_fmt, in_op, in_funct2, in_funct3, in_funct7,
               in_rs1, in_rs2, in_rs3, in_rd, in_imm12, in_immhi, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/rv_instr_encoder_fifo2.sv
// Two-entry FIFO with synchronous flush; head is the oldest entry, count is 0..2.
module enc_fifo2 #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [1:0]   count,
    output logic [W-1:0] head
);
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       push_ok;
    logic       pop_ok;

    assign push_ok = push && (count_reg != 2'd2) && !flush;
    assign pop_ok  = pop  && (count_reg != 2'd0) && !flush;

    for (genvar gi = 0; gi < 2; gi++) begin : g_row
        logic [W-1:0] row_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                row_reg <= '0;
            end else if (push_ok && (wr_ptr_reg == 1'(gi))) begin
                row_reg <= din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_reg <= !wr_ptr_reg;
            if (pop_ok)  rd_ptr_reg <= !rd_ptr_reg;
            count_reg <= count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign count = count_reg;
    assign head  = rd_ptr_reg ? g_row[1].row_reg : g_row[0].row_reg;
endmodule

// File: rtl/rv_instr_encoder.sv
// Packs decoded RV32IF fields into instruction words, rejects illegal format/opcode
// pairs, and queues legal words with sequential program addresses.
module rv_instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                prog_start,
    rv_instr_encoder_if.slave   bus,
    output logic                err,
    output logic [ERR_W-1:0]    err_count
);
    localparam int DW = 32 + ADDR_W;

    fmt_e              fmt;
    logic [31:0]       word;
    logic              legal;
    logic              accept;
    logic              push;
    logic              pop;
    logic [1:0]        count;
    logic [DW-1:0]     head;
    logic [ADDR_W-1:0] addr_cnt_reg;
    logic              err_reg;
    logic [ERR_W-1:0]  err_count_reg;

    assign fmt = fmt_e'(bus.in_fmt);

    // Field positions mirror the decoder exactly, so B keeps the raw imm order.
    always_comb begin
        word = 32'd0;
        case (fmt)
            FMT_R:        word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_op};
            FMT_I:        word = {bus.in_imm12, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_op};
            FMT_S, FMT_B: word = {bus.in_imm12[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                  bus.in_imm12[4:0], bus.in_op};
            FMT_U, FMT_J: word = {bus.in_immhi, bus.in_rd, bus.in_op};
            FMT_R4:       word = {bus.in_rs3, bus.in_funct2, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                  bus.in_rd, bus.in_op};
            default:      word = 32'd0;
        endcase
    end

    assign legal        = is_legal_op(fmt, bus.in_op);
    assign bus.in_ready = (count < 2'd2) && !prog_start;
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = accept && legal;
    assign pop          = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt_reg  <= '0;
            err_reg       <= 1'b0;
            err_count_reg <= '0;
        end else begin
            if (prog_start) begin
                addr_cnt_reg <= '0;
            end else if (push) begin
                addr_cnt_reg <= addr_cnt_reg + 1'b1;
            end
            err_reg <= accept && !legal;
            if (accept && !legal && (err_count_reg != '1)) begin
                err_count_reg <= err_count_reg + 1'b1;
            end
        end
    end

    enc_fifo2 #(.W(DW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (prog_start),
        .push  (push),
        .pop   (pop),
        .din   ({word, addr_cnt_reg}),
        .count (count),
        .head  (head)
    );

    assign bus.out_valid = (count != 2'd0);
    assign bus.out_instr = head[DW-1:ADDR_W];
    assign bus.out_addr  = head[ADDR_W-1:0];
    assign err           = err_reg;
    assign err_count     = err_count_reg;
endmodule

// File: tb/tb_rv_instr_encoder.sv
// Randomized and directed checks of rv_instr_encoder against a queue-based model.
module tb_rv_instr_encoder;
    logic       clk = 1'b0;
    logic       rst;
    logic       prog_start;
    logic       err;
    logic [7:0] err_count;

    rv_instr_encoder_if #(.ADDR_W(8)) bus ();

    rv_instr_encoder #(.ADDR_W(8), .ERR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_start (prog_start),
        .bus        (bus),
        .err        (err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        int          addr;
    } entry_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    entry_t q[$];
    int     m_addr   = 0;
    int     m_errcnt = 0;
    bit     m_err    = 1'b0;

    // {fmt, opcode} pairs that the encoder must accept
    logic [9:0] leg_tbl [16] = '{
        {3'd0, 7'h33}, {3'd0, 7'h53},
        {3'd1, 7'h03}, {3'd1, 7'h13}, {3'd1, 7'h67}, {3'd1, 7'h07},
        {3'd2, 7'h23}, {3'd2, 7'h27},
        {3'd3, 7'h63},
        {3'd4, 7'h17}, {3'd4, 7'h37},
        {3'd5, 7'h6F},
        {3'd6, 7'h43}, {3'd6, 7'h47}, {3'd6, 7'h4B}, {3'd6, 7'h4F}
    };

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_legal(input int fmt, input int op);
        for (int k = 0; k < 16; k++) begin
            if ((int'(leg_tbl[k][9:7]) == fmt) && (int'(leg_tbl[k][6:0]) == op)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Weighted-sum form of the field layout
    function automatic logic [31:0] model_encode();
        int unsigned op, rd, f3, rs1, rs2, rs3, f2, f7, imm, hi, w;
        op  = bus.in_op;     rd  = bus.in_rd;     f3  = bus.in_funct3;
        rs1 = bus.in_rs1;    rs2 = bus.in_rs2;    rs3 = bus.in_rs3;
        f2  = bus.in_funct2; f7  = bus.in_funct7; imm = bus.in_imm12;
        hi  = bus.in_immhi;
        case (int'(bus.in_fmt))
            0:       w = op + rd * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 1048576 + f7 * 33554432;
            1:       w = op + rd * 128 + f3 * 4096 + rs1 * 32768 + imm * 1048576;
            2, 3:    w = op + (imm % 32) * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 1048576
                         + (imm / 32) * 33554432;
            4, 5:    w = op + rd * 128 + hi * 4096;
            6:       w = op + rd * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 1048576
                         + f2 * 33554432 + rs3 * 134217728;
            default: w = 0;
        endcase
        return w;
    endfunction

    // One clock: check in_ready, advance the model, then check registered outputs.
    task automatic tick();
        bit exp_ready, acc, lg, pop;
        #1;
        exp_ready = (q.size() < 2) && !prog_start;
        if (!rst) check_val("in_ready", bus.in_ready, exp_ready);
        if (rst) begin
            q.delete(); m_addr = 0; m_errcnt = 0; m_err = 1'b0;
        end else if (prog_start) begin
            q.delete(); m_addr = 0; m_err = 1'b0;
        end else begin
            acc = bus.in_valid && exp_ready;
            lg  = model_legal(int'(bus.in_fmt), int'(bus.in_op));
            pop = (q.size() > 0) && bus.out_ready;
            if (pop) begin
                $display("pop  addr=%0d instr=0x%08h", q[0].addr, q[0].instr);
                void'(q.pop_front());
            end
            if (acc && lg) begin
                q.push_back('{instr: model_encode(), addr: m_addr});
                m_addr = (m_addr + 1) % 256;
            end
            m_err = acc && !lg;
            if (acc && !lg && m_errcnt < 255) m_errcnt++;
        end
        @(posedge clk);
        @(negedge clk);
        check_val("out_valid", bus.out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check_val("out_instr", bus.out_instr, q[0].instr);
            check_val("out_addr", bus.out_addr, q[0].addr);
        end
        check_val("err", err, m_err);
        check_val("err_count", err_count, m_errcnt);
    endtask

    task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [11:0] imm12, input logic [19:0] immhi);
        bus.in_fmt = fmt;   bus.in_op = op;   bus.in_funct3 = f3;
        bus.in_rs1 = rs1;   bus.in_rs2 = rs2; bus.in_rd = rd;
        bus.in_imm12 = imm12; bus.in_immhi = immhi;
        bus.in_funct2 = 2'd0; bus.in_funct7 = 7'd0; bus.in_rs3 = 5'd0;
    endtask

    task automatic random_fields();
        int k;
        if ($urandom_range(0, 3) != 0) begin
            k = $urandom_range(0, 15);
            bus.in_fmt = leg_tbl[k][9:7];
            bus.in_op  = leg_tbl[k][6:0];
        end else begin
            bus.in_fmt = 3'($urandom);
            bus.in_op  = 7'($urandom);
        end
        bus.in_funct2 = 2'($urandom); bus.in_funct3 = 3'($urandom); bus.in_funct7 = 7'($urandom);
        bus.in_rs1 = 5'($urandom); bus.in_rs2 = 5'($urandom); bus.in_rs3 = 5'($urandom);
        bus.in_rd = 5'($urandom); bus.in_imm12 = 12'($urandom); bus.in_immhi = 20'($urandom);
    endtask

    task automatic do_prog_start();
        bus.in_valid = 1'b0; prog_start = 1'b1; tick(); prog_start = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1; prog_start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        set_fields(3'd0, 7'h00, 3'd0, 5'd0, 5'd0, 5'd0, 12'd0, 20'd0);
        tick(); tick();
        check_val("rst_instr", bus.out_instr, 32'h0);
        check_val("rst_addr", bus.out_addr, 8'h0);
        rst = 1'b0;

        // R-type ADD x3,x1,x2
        set_fields(3'd0, 7'h33, 3'd0, 5'd1, 5'd2, 5'd3, 12'd0, 20'd0);
        bus.in_valid = 1'b1; tick(); bus.in_valid = 1'b0;
        check_val("r_word", bus.out_instr, 32'h002081B3);
        check_val("r_addr", bus.out_addr, 8'd0);
        bus.out_ready = 1'b1; tick();

        // ADDI then LUI, held in the FIFO
        do_prog_start();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        set_fields(3'd1, 7'h13, 3'd0, 5'd0, 5'd0, 5'd5, 12'h7FF, 20'd0); tick();
        set_fields(3'd4, 7'h37, 3'd0, 5'd0, 5'd0, 5'd1, 12'd0, 20'h12345); tick();
        bus.in_valid = 1'b0;
        check_val("i_word", bus.out_instr, 32'h7FF00293);
        check_val("i_addr", bus.out_addr, 8'd0);
        bus.out_ready = 1'b1; tick();
        check_val("u_word", bus.out_instr, 32'h123450B7);
        check_val("u_addr", bus.out_addr, 8'd1);
        tick();

        // SW with field round-trip through decoder positions
        set_fields(3'd2, 7'h23, 3'd2, 5'd1, 5'd2, 5'd0, 12'h008, 20'd0);
        bus.in_valid = 1'b1; bus.out_ready = 1'b0; tick(); bus.in_valid = 1'b0;
        w = bus.out_instr;
        check_val("s_word", w, 32'h0020A423);
        check_val("s_rt_imm", {w[31:25], w[11:7]}, 12'h008);
        check_val("s_rt_rs", {w[24:20], w[19:15], w[14:12]}, {5'd2, 5'd1, 3'd2});
        bus.out_ready = 1'b1; tick();

        // Illegal pairs: R with OP-IMM, then reserved format
        bus.in_valid = 1'b1;
        set_fields(3'd0, 7'h13, 3'd0, 5'd1, 5'd2, 5'd3, 12'd0, 20'd0); tick();
        check_val("ill_err", err, 1'b1);
        check_val("ill_cnt", err_count, 8'd1);
        set_fields(3'd7, 7'h33, 3'd0, 5'd1, 5'd2, 5'd3, 12'd0, 20'd0); tick();
        check_val("rsv_cnt", err_count, 8'd2);
        set_fields(3'd5, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd1, 12'd0, 20'hABCDE); tick();
        bus.in_valid = 1'b0;
        check_val("ill_err_clr", err, 1'b0);
        check_val("ill_next_addr", bus.out_addr, 8'd3);
        tick();

        // Backpressure: third bundle held until space frees
        do_prog_start();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_fields(3'd1, 7'h13, 3'd0, 5'(i), 5'd0, 5'(i + 1), 12'(i), 20'd0);
            tick();
        end
        check_val("bp_full", bus.in_ready, 1'b0);
        check_val("bp_head0", bus.out_addr, 8'd0);
        bus.out_ready = 1'b1; tick();
        check_val("bp_head1", bus.out_addr, 8'd1);
        tick();
        bus.in_valid = 1'b0;
        check_val("bp_head2", bus.out_addr, 8'd2);
        check_val("bp_head2_v", bus.out_valid, 1'b1);
        tick();

        // prog_start with two queued entries and addr_cnt=5
        do_prog_start();
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        set_fields(3'd3, 7'h63, 3'd1, 5'd4, 5'd6, 5'd0, 12'hA5A, 20'd0);
        tick(); tick(); tick();
        bus.in_valid = 1'b0; tick();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; tick(); tick();
        check_val("ps_head", bus.out_addr, 8'd3);
        prog_start = 1'b1; tick(); prog_start = 1'b0;
        check_val("ps_empty", bus.out_valid, 1'b0);
        check_val("ps_errcnt", err_count, 8'd2);
        tick();
        check_val("ps_addr0", bus.out_addr, 8'd0);

        // Address wrap at 255
        do_prog_start();
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        set_fields(3'd6, 7'h43, 3'd7, 5'd9, 5'd10, 5'd11, 12'd0, 20'd0);
        bus.in_rs3 = 5'd31; bus.in_funct2 = 2'd1;
        for (int i = 0; i < 256; i++) tick();
        check_val("wrap_255", bus.out_addr, 8'd255);
        tick();
        check_val("wrap_0", bus.out_addr, 8'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            random_fields();
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 4) < 3);
            prog_start    = ($urandom_range(0, 39) == 0);
            rst           = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; prog_start = 1'b0; bus.in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
